// File: rtl/vr_pkg.sv
// Shared definitions for the valid/ready source/sink pair: FSM encoding
// and default widths.
package vr_pkg;

  typedef enum logic [1:0] {
    DELAY = 2'b01,
    READY = 2'b10
  } sink_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DELAY_BITS  = 3;
  localparam int DEF_COUNT_WIDTH = 16;
  localparam int DEF_FIRST_VALUE = 1;

endpackage

// File: rtl/valid_ready.sv
// Valid/ready streaming bus; the master drives valid and data, the slave drives ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // count register: clear wins over increment, sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sink_checker.sv
// Valid/ready sink with programmable backpressure, incrementing-data checker
// and upstream protocol monitor.
module sink_checker
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DELAY_BITS  = DEF_DELAY_BITS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int FIRST_VALUE = DEF_FIRST_VALUE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_BITS-1:0]  delay,
  input  logic                   clear,
  valid_ready.Slave              vrBus,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic                   data_err,
  output logic                   proto_err,
  output logic [DATA_WIDTH-1:0]  expected
);

  localparam logic [DATA_WIDTH-1:0] FIRST_S = DATA_WIDTH'(FIRST_VALUE);

  sink_state_t           state_r;
  sink_state_t           state_nxt_s;
  logic [DELAY_BITS-1:0] cnt_r;
  logic [DELAY_BITS-1:0] cnt_nxt_s;
  logic [DELAY_BITS:0]   cnt_inc_s;

  logic                  hs_s;
  logic                  stall_s;
  logic                  mismatch_s;
  logic                  proto_viol_s;

  logic [DATA_WIDTH-1:0] expected_r;
  logic                  data_err_r;
  logic                  proto_err_r;
  logic                  prev_stall_r;
  logic [DATA_WIDTH-1:0] prev_data_r;
  logic                  armed_r;

  // ready never looks at valid, so there is no combinational loop through the bus
  assign vrBus.ready = (state_r == READY) || (delay == {DELAY_BITS{1'b0}});
  assign hs_s        = vrBus.valid && vrBus.ready;
  assign stall_s     = vrBus.valid && !vrBus.ready;
  assign cnt_inc_s   = {1'b0, cnt_r} + {{DELAY_BITS{1'b0}}, 1'b1};
  assign mismatch_s  = hs_s && (vrBus.data != expected_r);
  assign proto_viol_s = armed_r && prev_stall_r &&
                        (!vrBus.valid || (vrBus.data != prev_data_r));

  // backpressure FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      DELAY: begin
        if (hs_s) begin
          state_nxt_s = DELAY;
          cnt_nxt_s   = {DELAY_BITS{1'b0}};
        end else begin
          cnt_nxt_s = cnt_inc_s[DELAY_BITS-1:0];
          // >= so that lowering delay mid-count still releases ready
          if (cnt_inc_s >= {1'b0, delay}) begin
            state_nxt_s = READY;
          end else begin
            state_nxt_s = DELAY;
          end
        end
      end
      READY: begin
        if (hs_s) begin
          state_nxt_s = DELAY;
          cnt_nxt_s   = {DELAY_BITS{1'b0}};
        end else begin
          state_nxt_s = READY;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = DELAY;
        cnt_nxt_s   = {DELAY_BITS{1'b0}};
      end
    endcase
  end

  // FSM state register; clear deliberately does not touch it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= DELAY;
      cnt_r   <= {DELAY_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // data check, sticky flags and protocol history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_r   <= FIRST_S;
      data_err_r   <= 1'b0;
      proto_err_r  <= 1'b0;
      prev_stall_r <= 1'b0;
      prev_data_r  <= {DATA_WIDTH{1'b0}};
      armed_r      <= 1'b0;
    end else begin
      prev_stall_r <= stall_s;
      prev_data_r  <= vrBus.data;
      armed_r      <= 1'b1;
      if (clear) begin
        expected_r  <= FIRST_S;
        data_err_r  <= 1'b0;
        proto_err_r <= 1'b0;
      end else begin
        // resync to the received value so one glitch yields one error
        if (hs_s) begin
          expected_r <= vrBus.data + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          expected_r <= expected_r;
        end
        data_err_r  <= data_err_r || mismatch_s;
        proto_err_r <= proto_err_r || proto_viol_s;
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (hs_s && !clear),
    .count (xfer_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (mismatch_s && !clear),
    .count (err_count)
  );

  assign expected  = expected_r;
  assign data_err  = data_err_r;
  assign proto_err = proto_err_r;

endmodule
